// File: rtl/uart_pkg.sv
// Shared UART definitions for the TinyTapeout receiver and transmitter:
// frame FSM states and default line timing.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int UART_CLKS_PER_BIT = 16;
    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CNT_W        = $clog2(UART_CLKS_PER_BIT);

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
// RST_VAL is the value both flops take in reset (1 for an idle-high line).
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, recovers LSB-first bytes, pulses valid/error flags.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    localparam uart_state_e AFTER_DATA = PARITY;
`else
    localparam uart_state_e AFTER_DATA = STOP;
`endif

    logic                 rx_s;
    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 bit_done;
`ifdef UART_RX_PARITY_EN
    logic                 perr_q, perr_d;
    logic                 par_bad_q, par_bad_d;
`endif

    sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    assign bit_done = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d    = 1'b0;
        par_bad_d = par_bad_q;
`endif
        if (!ena) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (!rx_s) state_d = START;
                end
                // Start bit is re-checked at its centre so short low glitches are dropped.
                START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = rx_s ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        cnt_d          = '0;
                        shift_d[idx_q] = rx_s;
                        if (idx_q == IDX_LAST) state_d = AFTER_DATA;
                        else                   idx_d   = idx_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        cnt_d     = '0;
                        par_bad_d = ^{shift_q, rx_s};
                        state_d   = STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
                // Leaving for IDLE on the sampling edge lets a back-to-back start bit in at once.
                STOP: begin
                    if (bit_done) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                        if (!rx_s) begin
                            ferr_d = 1'b1;
                        end
`ifdef UART_RX_PARITY_EN
                        else if (par_bad_q) begin
                            perr_d = 1'b1;
                        end
`endif
                        else begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            perr_q    <= perr_d;
            par_bad_q <= par_bad_d;
`endif
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver: the receive-side counterpart to the team's UART transmitter in the TinyTapeout design.
- Samples an asynchronous serial line, recovers bytes LSB-first and presents each byte with a one-cycle valid pulse.
- Instanced inside the tt_um_* top: rx from a ui_in bit; data/status to uo_out.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit (≥4, even); HALF = CLKS_PER_BIT/2.
- DATA_BITS, 8, payload bits per frame.

Ports:
- clk  input  1  design clock.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  design enable; low forces the FSM to IDLE.
- rx  input  1  serial line, idle high, asynchronous to clk.
- data_out  output  DATA_BITS  last received byte; holds until the next frame completes.
- data_valid  output  1  one-cycle pulse, good frame received.
- frame_err  output  1  one-cycle pulse, stop bit sampled low.
- parity_err  output  1  one-cycle pulse, parity mismatch (UART_RX_PARITY_EN only; else constant 0).
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, synchroniser flops set to 1 (line idle).
- rx passes through a 2-flop synchroniser to give rx_s; the FSM uses only rx_s.
- States: IDLE, START, DATA, STOP; bit counter 0..CLKS_PER_BIT-1; bit index 0..DATA_BITS-1.
- IDLE: rx_s==0 → START, cnt=0.
- START: cnt counts up. At cnt==HALF-1, sample rx_s:
  - 0 → DATA, cnt=0, idx=0.
  - 1 → IDLE (glitch rejected, no pulse).
- DATA: at cnt==CLKS_PER_BIT-1, shift rx_s into bit idx (LSB first) and reset cnt. After idx==DATA_BITS-1 → STOP (or PARITY if enabled).
- STOP: at cnt==CLKS_PER_BIT-1, sample rx_s:
  - 1 → load data_out with the shift register, pulse data_valid.
  - 0 → pulse frame_err; data_out unchanged; no data_valid.
  - Either way → IDLE on the same edge, so a back-to-back start bit is accepted immediately.
- Latency: first edge at which the synchroniser's first flop captures rx=0 is edge 1; the stop bit is sampled at edge 3+HALF+(DATA_BITS+1)·CLKS_PER_BIT. data_valid is high for the cycle after that edge (edge 155 at defaults).
- Pulses: data_valid, frame_err and parity_err are never high two cycles in a row and never high together.
- ena low: FSM → IDLE and pulses forced 0 on the next edge; data_out holds; a partial frame is discarded.
- rx held low after a framing error: IDLE re-enters START immediately; the frame is treated as a new (likely bad) frame. No break detection.
- Mid-frame reset: asynchronous clear to reset values; the next clean frame is received correctly.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined: adds a PARITY state after DATA, timed like a data bit. Even parity is checked over the data bits plus the parity bit.
  - On a mismatch with a good stop bit: pulse parity_err instead of data_valid; data_out unchanged.
  - A bad stop bit gives frame_err only, which has priority over parity_err.
  - Latency to data_valid grows by CLKS_PER_BIT.
- Undefined: no PARITY state; parity_err tied 0.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - default CLKS_PER_BIT and DATA_BITS constants;
  - counter width localparam, $clog2(CLKS_PER_BIT).
  - Shared with the transmitter.
- One sub-module, sync_2ff: 2-flop synchroniser with reset value parameter (here 1), reusable for other ui_in inputs.

Test Plan:
- Reset then send 0x55 at CLKS_PER_BIT=16 → data_out=0x55, single data_valid pulse at edge 155, busy low afterwards, frame_err=0.
- Back-to-back frames 0xA3 then 0x3C with no idle gap → two data_valid pulses 160 cycles apart, data_out 0xA3 then 0x3C.
- rx low for 4 cycles then high → START aborts at mid-bit, back to IDLE, no pulses, data_out unchanged.
- 0x0F with stop bit driven 0 → frame_err pulse only, data_out keeps its previous value. A following good 0x81 gives data_valid with 0x81.
- rst_n asserted during DATA bit 4 of 0xFF → all outputs 0 immediately; a subsequent 0x12 is received correctly.
- Parity (UART_RX_PARITY_EN): 0x07 with parity bit 1 → data_valid, data_out=0x07. 0x07 with parity bit 0 → parity_err pulse, no data_valid.
